tap_clk_select: RTL and testbench
=================================

TAP_CLK_SELECT -- requirements
Module: tap_clk_select

Interface
REQ-001 Parameter NTAPS, default 11: number of power-of-two divider taps on the taps bus.
REQ-002 Parameter CNT_W, default 16: width of tick_cnt.
REQ-003 Parameter SEL_W, default 4: width of sel and active_sel; SEL_W SHALL satisfy 2^SEL_W >= NTAPS.
REQ-004 clk  in  1: single clock for all state; all logic SHALL be on rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 taps  in  NTAPS: divider taps, bit k toggles at f/2^(k+1), synchronous to clk.
REQ-007 sel  in  SEL_W: requested tap index.
REQ-008 sel_valid  in  1: sel request valid.
REQ-009 sel_ready  out  1: block can accept a request.
REQ-010 sel_err  out  1: one-cycle pulse, out-of-range request rejected.
REQ-011 div_clk  out  1: glitch-free registered copy of the active tap.
REQ-012 tick  out  1: one-cycle clock-enable strobe on each rising edge of the active tap.
REQ-013 tick_cnt  out  CNT_W: count of ticks since last reset or tap change.
REQ-014 active_sel  out  SEL_W: tap index currently driving div_clk and tick.

Function
REQ-015 The FSM SHALL have three states: RUN, DRAIN and GATE.
REQ-016 sel_ready SHALL be 1 only when state is RUN and reset is 0 (combinational from state).
REQ-017 A request SHALL be accepted on a cycle with sel_valid=1 and sel_ready=1; sel SHALL be captured into a pending register.
REQ-018 On acceptance with sel >= NTAPS, the request SHALL be rejected: sel_err=1 on the next cycle, state stays RUN, and active_sel is unchanged.
REQ-019 On acceptance with sel == active_sel, there SHALL be no state change and no counter clear.
REQ-020 On acceptance of any other valid sel, the FSM SHALL go RUN->DRAIN.
REQ-021 In RUN, div_clk SHALL be taps[active_sel] registered, giving 1-cycle latency.
REQ-022 In RUN, tick SHALL be 1 for exactly one cycle, the cycle after taps[active_sel] is sampled 1 while its previous sample was 0.
REQ-023 DRAIN: div_clk SHALL follow the old tap; when the old tap is sampled 0, div_clk SHALL be driven 0 and the FSM SHALL go to GATE.
REQ-024 GATE: div_clk SHALL be held 0; when taps[pending] is sampled 0, active_sel<=pending, the edge history register <=0, tick_cnt<=0, and the FSM SHALL go to RUN.
REQ-025 tick SHALL be 0 in DRAIN and GATE; div_clk SHALL never show a high pulse shorter than the shorter of the two tap high phases.
REQ-026 tick_cnt SHALL increment by 1 on each tick and wrap from 2^CNT_W-1 to 0 without a flag.
REQ-027 When tick and the GATE commit clear coincide, the clear SHALL win.
REQ-028 sel_valid outside RUN SHALL be ignored; the requester SHALL hold it until sel_ready.

Reset
REQ-029 While reset=1 on a clock edge, the following SHALL apply: state=RUN, active_sel=0, pending=0, edge history=0, div_clk=0, tick=0, sel_err=0, tick_cnt=0.
REQ-030 Reset asserted in DRAIN or GATE SHALL abandon the switch; the first cycle after reset SHALL be RUN on tap 0.
REQ-031 First tick after reset SHALL occur only on a genuine 0->1 of taps[0] sampled after reset.

Structure
REQ-032 A shared package div_pkg SHALL hold NTAPS, SEL_W, CNT_W defaults and the state enumeration (RUN, DRAIN, GATE).
REQ-033 The block SHALL contain one sub-module, tap_edge_det (registered sample plus rising-edge pulse, with synchronous clear).
REQ-034 Tap muxing SHALL use active_sel only; no combinational path SHALL exist from sel to div_clk.

Verification
Taps are driven from a free-running counter (taps[k]=cnt[k]), after a 2-cycle reset.

REQ-035 sel=0 steady, 20 cycles -> tick every 2 cycles, tick_cnt=10, div_clk period 2 cycles.
REQ-036 Request sel=3 while on tap 0 -> sel_ready low through DRAIN/GATE, no tick, div_clk no runt pulse, then active_sel=3, tick_cnt=0, tick every 16 cycles.
REQ-037 Request sel=11 (NTAPS=11) -> sel_err one-cycle pulse, active_sel unchanged, tick cadence unchanged.
REQ-038 Request sel equal to active_sel -> no sel_err, tick_cnt not cleared, no gap in ticks.
REQ-039 reset pulsed during GATE (0->5 switch) -> next cycle active_sel=0, div_clk=0, tick_cnt=0, RUN.
REQ-040 CNT_W=4, sel=0, 16 ticks -> tick_cnt wraps 15->0; tick coinciding with GATE commit leaves tick_cnt=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared defaults, FSM state encoding and a range helper for the tap clock selector.
package div_pkg;

  localparam int NTAPS_DEF = 11;
  localparam int SEL_W_DEF = 4;
  localparam int CNT_W_DEF = 16;

  // RUN: steady on active tap; DRAIN: let old tap fall; GATE: hold low until new tap is low.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    GATE  = 2'd2
  } state_e;

  // A request index is usable only if it names an existing tap.
  function automatic logic sel_in_range(input logic [31:0] idx, input int unsigned ntaps);
    return idx < ntaps;
  endfunction

endpackage

// File: rtl/tap_clk_select_if.sv
// Tap-select request channel: valid/ready handshake plus a one-cycle reject pulse.
interface tap_clk_select_if #(
  parameter int SEL_W = 4
);
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic             sel_ready;
  logic             sel_err;

  modport master (output sel, output sel_valid, input sel_ready, input sel_err);
  modport slave  (input sel, input sel_valid, output sel_ready, output sel_err);
endinterface

// File: rtl/tap_edge_det.sv
// Registered tap sample with a rising-edge strobe.
// 'armed' keeps the first sample after reset from counting as an edge, since
// the history register is zeroed there regardless of the tap's real level.
module tap_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  input  logic en,
  input  logic clr,
  output logic q,
  output logic rise,
  output logic rise_nxt
);
  logic armed;

  assign rise_nxt = en & armed & d & ~q & ~clr;

  // Sample history and strobe; clr restarts history from a known-low tap.
  always_ff @(posedge clk) begin
    if (reset) begin
      q     <= 1'b0;
      rise  <= 1'b0;
      armed <= 1'b0;
    end else begin
      q     <= clr ? 1'b0 : d;
      rise  <= rise_nxt;
      armed <= 1'b1;
    end
  end
endmodule

// File: rtl/tap_clk_select.sv
// Glitch-free power-of-two tap selector with tick strobe and tick counter.
// A switch drains the old tap to low, holds the output low, and only commits
// once the new tap is also low, so div_clk never shows a runt high pulse.
// SEL_W must satisfy 2**SEL_W >= NTAPS.
module tap_clk_select
  import div_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NTAPS-1:0]     taps,
  tap_clk_select_if.slave      req,
  output logic                 div_clk,
  output logic                 tick,
  output logic [CNT_W-1:0]     tick_cnt,
  output logic [SEL_W-1:0]     active_sel
);
  state_e           state, nxt;
  logic [SEL_W-1:0] pending;
  logic             sel_err_q;
  logic             accept, in_range, commit;
  logic             tap_old, tap_new;
  logic             edge_d, edge_en, rise_nxt;

  assign req.sel_ready = (state == RUN) && !reset;
  assign req.sel_err   = sel_err_q;
  assign accept        = req.sel_valid && req.sel_ready;
  assign in_range      = sel_in_range(32'(req.sel), NTAPS);

  // Only registered indices steer the mux; sel never reaches div_clk directly.
  assign tap_old = taps[active_sel];
  assign tap_new = taps[pending];

  // Next state: start a switch, wait for old tap low, wait for new tap low.
  always_comb begin
    nxt    = state;
    commit = 1'b0;
    case (state)
      RUN:     if (accept && in_range && (req.sel != active_sel)) nxt = DRAIN;
      DRAIN:   if (!tap_old) nxt = GATE;
      GATE:    if (!tap_new) begin
                 nxt    = RUN;
                 commit = 1'b1;
               end
      default: nxt = RUN;
    endcase
  end

  // State, selection registers and reject pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      active_sel <= '0;
      pending    <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      state     <= nxt;
      sel_err_q <= accept && !in_range;
      if (accept) pending <= req.sel;
      if (commit) active_sel <= pending;
    end
  end

  // Output is forced low while gated; ticks only in cycles that will be RUN.
  assign edge_d  = tap_old & (state != GATE);
  assign edge_en = (nxt == RUN);

  tap_edge_det u_edge (
    .clk      (clk),
    .reset    (reset),
    .d        (edge_d),
    .en       (edge_en),
    .clr      (commit),
    .q        (div_clk),
    .rise     (tick),
    .rise_nxt (rise_nxt)
  );

  // Tick counter; a commit clear beats a coincident tick, wraps silently.
  always_ff @(posedge clk) begin
    if (reset || commit) tick_cnt <= '0;
    else if (rise_nxt)   tick_cnt <= tick_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_tap_clk_select.sv
// Directed bench: taps come from a free-running counter that equals the edge
// number k after edge k, so the DUT samples cnt = k-1 at edge k.
module tb_tap_clk_select;
  localparam int NT = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   cnt = '0;
  logic [NT-1:0] taps;

  logic          div_clk, tick, div_clk4, tick4;
  logic [15:0]   tick_cnt;
  logic [3:0]    tick_cnt4;
  logic [3:0]    active_sel, active_sel4;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;

  tap_clk_select_if #(.SEL_W(4)) bus ();
  tap_clk_select_if #(.SEL_W(4)) bus4 ();

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 16'd1;
  assign taps = cnt[NT-1:0];

  tap_clk_select #(.NTAPS(NT), .CNT_W(16), .SEL_W(4)) dut (
    .clk(clk), .reset(reset), .taps(taps), .req(bus),
    .div_clk(div_clk), .tick(tick), .tick_cnt(tick_cnt), .active_sel(active_sel)
  );

  tap_clk_select #(.NTAPS(NT), .CNT_W(4), .SEL_W(4)) dut4 (
    .clk(clk), .reset(reset), .taps(taps), .req(bus4),
    .div_clk(div_clk4), .tick(tick4), .tick_cnt(tick_cnt4), .active_sel(active_sel4)
  );

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s at k=%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  initial begin
    bus.sel = '0;  bus.sel_valid = 1'b0;
    bus4.sel = '0; bus4.sel_valid = 1'b0;

    // two reset edges
    step(); step();
    chk("rst_div", div_clk, 0);
    chk("rst_tick", tick, 0);
    chk("rst_cnt", tick_cnt, 0);
    chk("rst_act", active_sel, 0);
    chk("rst_rdy", bus.sel_ready, 0);
    chk("rst_err", bus.sel_err, 0);
    reset = 1'b0;
    #1;
    chk("run_rdy", bus.sel_ready, 1);

    // tap 0 steady: first tick after edge 4, then every 2 cycles
    step();
    chk("t0_first", tick, 0);
    step();
    chk("t0_tick", tick, 1);
    chk("t0_cnt1", tick_cnt, 1);
    chk("t0_div", div_clk, 1);
    while (k < 22) step();
    chk("t0_cnt10", tick_cnt, 10);
    chk("t0_tick22", tick, 1);
    chk("t0_cnt4_10", tick_cnt4, 10);
    step();
    chk("t0_tick23", tick, 0);
    chk("t0_div23", div_clk, 0);

    // out-of-range request: pulse, no switch, cadence unchanged
    bus.sel = 4'd11; bus.sel_valid = 1'b1;
    step();
    bus.sel_valid = 1'b0;
    chk("oor_err", bus.sel_err, 1);
    chk("oor_act", active_sel, 0);
    chk("oor_tick", tick, 1);
    chk("oor_cnt", tick_cnt, 11);
    chk("oor_rdy", bus.sel_ready, 1);
    step();
    chk("oor_err_off", bus.sel_err, 0);
    step();
    chk("oor_tick26", tick, 1);
    chk("oor_cnt26", tick_cnt, 12);

    // same-tap request: nothing changes
    bus.sel = 4'd0; bus.sel_valid = 1'b1;
    step();
    bus.sel_valid = 1'b0;
    chk("same_err", bus.sel_err, 0);
    chk("same_rdy", bus.sel_ready, 1);
    chk("same_cnt", tick_cnt, 12);
    step();
    chk("same_tick", tick, 1);
    chk("same_cnt28", tick_cnt, 13);

    // switch 0 -> 3: accept at edge 29, drain to 31, gate, commit at 33
    bus.sel = 4'd3; bus.sel_valid = 1'b1;
    step();
    bus.sel_valid = 1'b0;
    chk("sw_rdy29", bus.sel_ready, 0);
    chk("sw_tick29", tick, 0);
    chk("sw_div29", div_clk, 0);
    step();
    chk("sw_div30", div_clk, 1);
    chk("sw_rdy30", bus.sel_ready, 0);
    chk("sw_tick30", tick, 0);
    step();
    chk("sw_div31", div_clk, 0);
    chk("sw_rdy31", bus.sel_ready, 0);
    chk("sw_tick31", tick, 0);
    step();
    chk("sw_div32", div_clk, 0);
    chk("sw_rdy32", bus.sel_ready, 0);
    chk("sw_tick32", tick, 0);
    chk("w4_cnt15", tick_cnt4, 15);
    step();
    chk("sw_act33", active_sel, 3);
    chk("sw_cnt33", tick_cnt, 0);
    chk("sw_rdy33", bus.sel_ready, 1);
    chk("sw_div33", div_clk, 0);
    chk("sw_tick33", tick, 0);

    // tap 3 cadence on dut; wrap and commit-clear on dut4
    for (int i = 0; i < 24; i++) begin
      if (k == 38) begin bus4.sel = 4'd1; bus4.sel_valid = 1'b1; end
      step();
      if (k == 39) bus4.sel_valid = 1'b0;
      chk("t3_tick", tick, 32'(k == 41 || k == 57));
      chk("t3_div", div_clk, 32'(((k - 1) >> 3) & 1));
      if (k == 41) chk("t3_cnt41", tick_cnt, 1);
      if (k == 57) chk("t3_cnt57", tick_cnt, 2);
      if (k == 34) begin chk("w4_wrap", tick_cnt4, 0); chk("w4_tick34", tick4, 1); end
      if (k == 38) chk("w4_cnt38", tick_cnt4, 2);
      if (k == 39) chk("w4_rdy39", bus4.sel_ready, 0);
      if (k == 42) begin
        chk("w4_act42", active_sel4, 1);
        chk("w4_clr42", tick_cnt4, 0);
        chk("w4_tick42", tick4, 0);
        chk("w4_rdy42", bus4.sel_ready, 1);
      end
      if (k == 43) begin chk("w4_tick43", tick4, 1); chk("w4_cnt43", tick_cnt4, 1); end
    end

    // reset pulse returns to tap 0 and clears the counter
    reset = 1'b1;
    step();
    chk("r2_cnt", tick_cnt, 0);
    chk("r2_act", active_sel, 0);
    chk("r2_div", div_clk, 0);
    reset = 1'b0;
    step();
    chk("r2_tick59", tick, 0);

    // switch 0 -> 5, reset while in GATE abandons it
    bus.sel = 4'd5; bus.sel_valid = 1'b1;
    step();
    bus.sel_valid = 1'b0;
    chk("g_rdy60", bus.sel_ready, 0);
    step();
    chk("g_rdy61", bus.sel_ready, 0);
    step();
    chk("g_rdy62", bus.sel_ready, 0);
    chk("g_div62", div_clk, 0);
    reset = 1'b1;
    step();
    chk("g_act63", active_sel, 0);
    chk("g_div63", div_clk, 0);
    chk("g_cnt63", tick_cnt, 0);
    chk("g_tick63", tick, 0);
    reset = 1'b0;
    #1;
    chk("g_rdy63", bus.sel_ready, 1);
    step();
    chk("g_tick64", tick, 0);
    chk("g_div64", div_clk, 1);
    chk("g_act64", active_sel, 0);
    step();
    chk("g_act65", active_sel, 0);
    chk("g_rdy65", bus.sel_ready, 1);
    chk("g_tick65", tick, 0);
    step();
    chk("g_tick66", tick, 1);
    chk("g_cnt66", tick_cnt, 1);
    chk("g_act66", active_sel, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
